// File: rtl/wbuffer_ctrl_pkg.sv
// Types and helpers for the store write buffer: request/response structs, entry
// layout, drain FSM states and byte-mask helpers. Load forwarding is optional and
// enabled by defining WBUF_FWD_EN.
package wbuffer_ctrl_pkg;

    localparam int ROB_W = 6;

    typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2, MSIZE8 = 2'd3} msize_t;

    typedef struct packed {
        logic             valid;
        msize_t           msize;
        logic [63:0]      addr;
        logic [63:0]      data;
        logic [ROB_W-1:0] rob_addr;
    } wbuffer_wreq_t;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob_addr;
    } wbuffer_creq_t;

    // Store data is right-justified: data byte 0 belongs to byte address addr.
    typedef struct packed {
        msize_t           msize;
        logic [63:0]      addr;
        logic [63:0]      data;
        logic [ROB_W-1:0] rob_addr;
    } wbuffer_entry_t;

    typedef struct packed {
        logic        valid;
        msize_t      msize;
        logic [63:0] addr;
    } wbuffer_rreq_t;

    typedef struct packed {
        logic        hit;
        logic        stall;
        logic [63:0] data;
    } wbuffer_rresp_t;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} wbuf_state_t;

    function automatic logic [3:0] msize_bytes(msize_t msize);
        return 4'd1 << msize;
    endfunction

    // Byte lanes touched within the 8-byte word; lanes past byte 7 are dropped.
    function automatic logic [7:0] msize2mask(msize_t msize, logic [2:0] off);
        logic [7:0] base;
        case (msize)
            MSIZE1:  base = 8'h01;
            MSIZE2:  base = 8'h03;
            MSIZE4:  base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // True when a misaligned access runs past the end of its 8-byte word.
    function automatic logic mspill(msize_t msize, logic [2:0] off);
        return ({1'b0, off} + msize_bytes(msize)) > 4'd8;
    endfunction

    function automatic logic [63:0] msize2dmask(msize_t msize);
        case (msize)
            MSIZE1:  return 64'h0000_0000_0000_00FF;
            MSIZE2:  return 64'h0000_0000_0000_FFFF;
            MSIZE4:  return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/wbuffer_fwd.sv
// Load-forwarding scan for the write buffer (used only when WBUF_FWD_EN is defined).
// Walks valid entries youngest first; the first same-word entry that overlaps the
// load decides the answer: full cover forwards data, partial overlap stalls.
module wbuffer_fwd
    import wbuffer_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wbuffer_entry_t               entries_i [DEPTH],
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [$clog2(DEPTH)-1:0]     tail_idx_i,
    input  wbuffer_rreq_t                rreq_i,
    output wbuffer_rresp_t               rresp_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] idx;
    logic [7:0]       lmask;
    logic [7:0]       smask;
    logic             lspill;
    logic             found;
    logic [2:0]       shift;

    // Youngest-first priority scan starting just below the tail.
    always_comb begin
        rresp_o = '0;
        found   = 1'b0;
        idx     = '0;
        smask   = '0;
        shift   = '0;
        lmask   = msize2mask(rreq_i.msize, rreq_i.addr[2:0]);
        lspill  = mspill(rreq_i.msize, rreq_i.addr[2:0]);
        for (int k = 0; k < DEPTH; k++) begin
            idx   = tail_idx_i - IDX_W'(k + 1);
            smask = msize2mask(entries_i[idx].msize, entries_i[idx].addr[2:0]);
            if (!found && rreq_i.valid && valid_i[idx] &&
                entries_i[idx].addr[63:3] == rreq_i.addr[63:3] && (smask & lmask) != 8'h00) begin
                found = 1'b1;
                if (!lspill && (lmask & ~smask) == 8'h00) begin
                    shift         = rreq_i.addr[2:0] - entries_i[idx].addr[2:0];
                    rresp_o.hit   = 1'b1;
                    rresp_o.data  = (entries_i[idx].data >> {shift, 3'b000}) & msize2dmask(rreq_i.msize);
                end else begin
                    rresp_o.stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wbuffer_ctrl.sv
// Store write buffer between commit and the D-cache. Stores enter in program order,
// are marked committed by the ROB, and committed stores drain one at a time.
// Flush drops everything not yet committed. Define WBUF_FWD_EN for exact load
// forwarding; otherwise any same-word match conservatively stalls the load.
module wbuffer_ctrl
    import wbuffer_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  wbuffer_wreq_t  wreq,
    output logic           wreq_ready,
    input  wbuffer_creq_t  creq,
    input  logic           flush,
    input  wbuffer_rreq_t  rreq,
    output wbuffer_rresp_t rresp,
    output logic           dreq_valid,
    output logic [63:0]    dreq_addr,
    output logic [63:0]    dreq_data,
    output msize_t         dreq_msize,
    input  logic           dreq_ready,
    input  logic           dresp_valid,
    output logic           empty,
    output logic           commit_err,
    output wbuf_state_t    dbg_state_o
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    wbuffer_entry_t   mem_q [DEPTH];
    logic [DEPTH-1:0] committed_q;
    logic [PTR_W-1:0] head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
    logic [PTR_W-1:0] count;
    logic             commit_err_q, commit_err_d;
    wbuf_state_t      state_q;
    logic             dreq_valid_q;
    logic             full, push, pop, commit_ok;
    logic [IDX_W-1:0] rel;
    logic [DEPTH-1:0] valid_mask;

    // Ring status: wrap bits differ with equal indices means full.
    assign count      = tail_q - head_q;
    assign full       = (head_q[PTR_W-1] != tail_q[PTR_W-1]) && (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
    assign empty      = (head_q == tail_q);
    assign wreq_ready = !full && !flush;
    assign push       = wreq.valid && wreq_ready;
    assign pop        = (state_q == WAIT) && dresp_valid;
    assign commit_ok  = creq.valid && (cptr_q != tail_q) &&
                        (mem_q[cptr_q[IDX_W-1:0]].rob_addr == creq.rob_addr);

    // Next pointers; flush rewinds the tail after this cycle's commit lands.
    always_comb begin
        head_d       = head_q + PTR_W'(pop);
        cptr_d       = cptr_q + PTR_W'(commit_ok);
        tail_d       = flush ? cptr_d : tail_q + PTR_W'(push);
        commit_err_d = commit_err_q | (creq.valid && !commit_ok);
    end

    // Pointer, commit-bit and sticky error state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q       <= '0;
            cptr_q       <= '0;
            tail_q       <= '0;
            committed_q  <= '0;
            commit_err_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            cptr_q       <= cptr_d;
            tail_q       <= tail_d;
            commit_err_q <= commit_err_d;
            if (pop)       committed_q[head_q[IDX_W-1:0]] <= 1'b0;
            if (push)      committed_q[tail_q[IDX_W-1:0]] <= 1'b0;
            if (commit_ok) committed_q[cptr_q[IDX_W-1:0]] <= 1'b1;
        end
    end

    // Entry payload storage; written only on enqueue, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q[IDX_W-1:0]] <= '{msize: wreq.msize, addr: wreq.addr,
                                          data: wreq.data, rob_addr: wreq.rob_addr};
        end
    end

    // Drain FSM: one committed store at a time, dreq_valid registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            dreq_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (head_q != cptr_q && committed_q[head_q[IDX_W-1:0]]) begin
                        state_q      <= ISSUE;
                        dreq_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (dreq_ready) begin
                        state_q      <= WAIT;
                        dreq_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dresp_valid) state_q <= IDLE;
                end
                default: begin
                    state_q      <= IDLE;
                    dreq_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dreq_valid  = dreq_valid_q;
    assign dreq_addr   = mem_q[head_q[IDX_W-1:0]].addr;
    assign dreq_data   = mem_q[head_q[IDX_W-1:0]].data;
    assign dreq_msize  = mem_q[head_q[IDX_W-1:0]].msize;
    assign commit_err  = commit_err_q;
    assign dbg_state_o = state_q;

    // Occupied-slot mask: slot i is live when its distance from head is below count.
    always_comb begin
        rel        = '0;
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel           = IDX_W'(i) - head_q[IDX_W-1:0];
            valid_mask[i] = ({1'b0, rel} < count);
        end
    end

`ifdef WBUF_FWD_EN
    wbuffer_fwd #(.DEPTH(DEPTH)) u_fwd (
        .entries_i  (mem_q),
        .valid_i    (valid_mask),
        .tail_idx_i (tail_q[IDX_W-1:0]),
        .rreq_i     (rreq),
        .rresp_o    (rresp)
    );
`else
    logic unused_rreq_bits;
    assign unused_rreq_bits = ^{rreq.msize, rreq.addr[2:0]};

    // Conservative lookup: any live store to the same 8-byte word stalls the load.
    always_comb begin
        rresp = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rreq.valid && valid_mask[i] && mem_q[i].addr[63:3] == rreq.addr[63:3])
                rresp.stall = 1'b1;
        end
    end
`endif

endmodule
